// File: rtl/incr_skid_stage.sv
// Purpose: registered +1 stage with a 2-entry skid buffer and a bounded input run (LIMIT transfers).
// Latency: 1 cycle (sample accepted at edge N is on out_data after edge N); 1 sample/cycle under out_ready=1.
// Backpressure: in_ready is driven by registers only (low when both entries are full or the run is done).
// Optional: define INCR_SKID_SATURATE_EN to saturate at 2**W-1 instead of wrapping to 0.
module incr_skid_stage #(
    parameter int W     = 4,
    parameter int LIMIT = 5,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_wrap,
    output logic [CW-1:0] xfer_cnt,
    output logic          done
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]   state;
    logic [W-1:0] main_data;
    logic         main_wrap;
    logic [W-1:0] skid_data;
    logic         skid_wrap;
    logic [W-1:0] inc_data;
    logic         inc_wrap;
    logic         in_hs;
    logic         out_hs;

    // Both ready and valid come straight from state registers, so no
    // combinational path exists from out_ready to in_ready.
    assign in_ready  = (state != ST_TWO) && !done;
    assign out_valid = (state != ST_EMPTY);
    assign out_data  = main_data;
    assign out_wrap  = main_wrap;
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;

    // Increment at acceptance; the output side only ever replays stored pairs.
    always_comb begin
        inc_wrap = (in_data == {W{1'b1}});
`ifdef INCR_SKID_SATURATE_EN
        inc_data = inc_wrap ? in_data : in_data + W'(1);
`else
        inc_data = in_data + W'(1);
`endif
    end

    // Occupancy FSM: main entry drives the outputs, skid catches the sample
    // that arrives while main is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            main_data <= '0;
            main_wrap <= 1'b0;
            skid_data <= '0;
            skid_wrap <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_hs) begin
                        main_data <= inc_data;
                        main_wrap <= inc_wrap;
                        state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    case ({in_hs, out_hs})
                        2'b10: begin
                            skid_data <= inc_data;
                            skid_wrap <= inc_wrap;
                            state     <= ST_TWO;
                        end
                        2'b01: begin
                            state <= ST_EMPTY;
                        end
                        2'b11: begin
                            main_data <= inc_data;
                            main_wrap <= inc_wrap;
                        end
                        default: begin
                        end
                    endcase
                end
                ST_TWO: begin
                    if (out_hs) begin
                        main_data <= skid_data;
                        main_wrap <= skid_wrap;
                        state     <= ST_ONE;
                    end
                end
                default: begin
                    state <= ST_EMPTY;
                end
            endcase
        end
    end

    // Transfer counter; done latches on the edge the count reaches LIMIT and
    // closes the input until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
            done     <= 1'b0;
        end else if (in_hs) begin
            xfer_cnt <= xfer_cnt + CW'(1);
            if ((xfer_cnt + CW'(1)) == CW'(LIMIT)) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_incr_skid_stage.sv
module tb_incr_skid_stage;
    localparam int W     = 4;
    localparam int LIMIT = 5;
    localparam int CW    = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_wrap;
    logic [CW-1:0] xfer_cnt;
    logic          done;

    int checks   = 0;
    int failures = 0;

    incr_skid_stage #(.W(W), .LIMIT(LIMIT), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_wrap  (out_wrap),
        .xfer_cnt  (xfer_cnt),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Reference result {wrap, data} from plain arithmetic.
    function automatic logic [W:0] ref_inc(input logic [W-1:0] d);
        int v;
        int vmax;
        v    = int'(d) + 1;
        vmax = (1 << W) - 1;
        if (v > vmax) begin
`ifdef INCR_SKID_SATURATE_EN
            return {1'b1, W'(vmax)};
`else
            return {1'b1, W'(0)};
`endif
        end
        return {1'b0, W'(v)};
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0d want=0", out_valid); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%0d want=0", out_data); end
        checks++; if (out_wrap !== 1'b0) begin failures++; $display("FAIL reset_out_wrap got=%0d want=0", out_wrap); end
        checks++; if (xfer_cnt !== '0) begin failures++; $display("FAIL reset_xfer_cnt got=%0d want=0", xfer_cnt); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0d want=0", done); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0d want=1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL idle_out_valid got=%0d want=0", out_valid); end
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < LIMIT; i++) begin
            in_valid = 1'b1;
            in_data  = W'(i);
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready[%0d] got=%0d want=1", i, in_ready); end
            @(posedge clk);
            #1;
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stream_out_valid[%0d] got=%0d want=1", i, out_valid); end
            checks++; if (out_data !== W'(i + 1)) begin failures++; $display("FAIL stream_out_data[%0d] got=%0d want=%0d", i, out_data, i + 1); end
            checks++; if (xfer_cnt !== CW'(i + 1)) begin failures++; $display("FAIL stream_xfer_cnt[%0d] got=%0d want=%0d", i, xfer_cnt, i + 1); end
            checks++; if (done !== (i == LIMIT - 1)) begin failures++; $display("FAIL stream_done[%0d] got=%0d want=%0d", i, done, (i == LIMIT - 1)); end
        end
        in_data = W'(9);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stream_closed_in_ready got=%0d want=0", in_ready); end
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_drained got=%0d want=0", out_valid); end
        checks++; if (xfer_cnt !== CW'(LIMIT)) begin failures++; $display("FAIL stream_final_cnt got=%0d want=%0d", xfer_cnt, LIMIT); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL stream_done_hold got=%0d want=1", done); end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = W'(7);
        @(posedge clk); #1;
        in_data = W'(8);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_one got=%0d want=1", in_ready); end
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_two got=%0d want=0", in_ready); end
        in_data = W'(9);
        @(posedge clk); #1;
        checks++; if (out_data !== W'(8)) begin failures++; $display("FAIL bp_hold_data got=%0d want=8", out_data); end
        checks++; if (xfer_cnt !== CW'(2)) begin failures++; $display("FAIL bp_cnt got=%0d want=2", xfer_cnt); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_still_two got=%0d want=0", in_ready); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_data !== W'(9)) begin failures++; $display("FAIL bp_second_out got=%0d want=9", out_data); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_reopen got=%0d want=1", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_data !== W'(10)) begin failures++; $display("FAIL bp_third_out got=%0d want=10", out_data); end
        checks++; if (xfer_cnt !== CW'(3)) begin failures++; $display("FAIL bp_cnt_after got=%0d want=3", xfer_cnt); end
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%0d want=0", out_valid); end
    endtask

    task automatic test_wrap();
        logic [W:0] exp15;
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = W'(15);
        @(posedge clk); #1;
`ifdef INCR_SKID_SATURATE_EN
        exp15 = {1'b1, W'(15)};
`else
        exp15 = {1'b1, W'(0)};
`endif
        checks++; if ({out_wrap, out_data} !== exp15) begin failures++; $display("FAIL wrap_15 got=%0d/%0d want=%0d/%0d", out_wrap, out_data, exp15[W], exp15[W-1:0]); end
        in_data = W'(14);
        @(posedge clk); #1;
        checks++; if ({out_wrap, out_data} !== {1'b0, W'(15)}) begin failures++; $display("FAIL wrap_14 got=%0d/%0d want=0/15", out_wrap, out_data); end
        in_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = W'(3);
        @(posedge clk); #1;
        in_data = W'(4);
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL ar_full got=%0d want=0", in_ready); end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ar_out_valid got=%0d want=0", out_valid); end
        checks++; if (xfer_cnt !== '0) begin failures++; $display("FAIL ar_xfer_cnt got=%0d want=0", xfer_cnt); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL ar_done got=%0d want=0", done); end
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ar_no_stale got=%0d want=0", out_valid); end
        in_valid = 1'b1;
        in_data  = W'(10);
        @(posedge clk); #1;
        checks++; if (out_data !== W'(11) || out_valid !== 1'b1) begin failures++; $display("FAIL ar_first_new got=%0d valid=%0d want=11 valid=1", out_data, out_valid); end
        in_valid = 1'b0;
    endtask

    task automatic test_random();
        logic [W:0] q[$];
        int cnt;
        int outs;
        logic exp_rdy;
        logic do_in;
        logic do_out;
        do_reset();
        cnt  = 0;
        outs = 0;
        for (int c = 0; c < 220; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = W'($urandom);
            out_ready = (c >= 200) ? 1'b1 : 1'($urandom_range(0, 1));
            exp_rdy   = (q.size() < 2) && (cnt < LIMIT);
            checks++; if (out_valid !== (q.size() > 0)) begin failures++; $display("FAIL rnd_out_valid[%0d] got=%0d want=%0d", c, out_valid, (q.size() > 0)); end
            checks++; if (in_ready !== exp_rdy) begin failures++; $display("FAIL rnd_in_ready[%0d] got=%0d want=%0d", c, in_ready, exp_rdy); end
            checks++; if (xfer_cnt !== CW'(cnt)) begin failures++; $display("FAIL rnd_xfer_cnt[%0d] got=%0d want=%0d", c, xfer_cnt, cnt); end
            checks++; if (done !== (cnt == LIMIT)) begin failures++; $display("FAIL rnd_done[%0d] got=%0d want=%0d", c, done, (cnt == LIMIT)); end
            if (q.size() > 0) begin
                checks++; if ({out_wrap, out_data} !== q[0]) begin failures++; $display("FAIL rnd_out[%0d] got=%0d/%0d want=%0d/%0d", c, out_wrap, out_data, q[0][W], q[0][W-1:0]); end
            end
            do_out = (q.size() > 0) && out_ready;
            do_in  = in_valid && exp_rdy;
            if (do_out) begin
                void'(q.pop_front());
                outs++;
            end
            if (do_in) begin
                q.push_back(ref_inc(in_data));
                cnt++;
            end
            @(posedge clk); #1;
        end
        checks++; if (outs != LIMIT) begin failures++; $display("FAIL rnd_total_outputs got=%0d want=%0d", outs, LIMIT); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rnd_final_empty got=%0d want=0", out_valid); end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_wrap();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
